// File: rtl/elastic_stage_buf_if.sv
// ---------------------------------------------------------------------------
// elastic_stage_buf_if
//   One valid/ready/data handshake channel between pipeline stages.
//   master : drives valid and data, observes ready (producer side)
//   slave  : observes valid and data, drives ready (consumer side)
// Parameters
//   DATA_W  payload width
// ---------------------------------------------------------------------------
interface elastic_stage_buf_if #(
    parameter int DATA_W = 640
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/elastic_stage_buf.sv
// ---------------------------------------------------------------------------
// elastic_stage_buf
//   Elastic pipeline register: a DEPTH-entry circular buffer with valid/ready
//   handshakes on both sides, flush, external freeze and an occupancy output.
//   Push and pop only happen on clock edges, so a payload pushed at one edge is
//   visible on the output from the following cycle (no fall-through).
//
// Ports
//   clk             clock
//   rst             synchronous, active-high reset
//   flush_i         drop all held entries at the next edge (wins over all)
//   freeze_i        stage frozen: no push, no pop, state held
//   up_if (slave)   upstream channel: valid/data in, ready out
//   dn_if (master)  downstream channel: valid/data out, ready in;
//                   data reads 0 when the buffer is empty
//   count_o         number of held entries
//   stall_cycles_o  cycles with upstream valid but not ready (saturating)
//   full_cycles_o   cycles with count == DEPTH (saturating)
//
// Configuration
//   ELASTIC_PERF_CNT_EN  when defined, adds CNT_W, the two perf counter
//                        outputs and their counters; cleared by rst only.
// ---------------------------------------------------------------------------
module elastic_stage_buf #(
    parameter int DATA_W = 640,
    parameter int DEPTH  = 2
`ifdef ELASTIC_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       freeze_i,
    elastic_stage_buf_if.slave         up_if,
    elastic_stage_buf_if.master        dn_if,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef ELASTIC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]           stall_cycles_o,
    output logic [CNT_W-1:0]           full_cycles_o
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    // Keep pointers at least one bit wide so DEPTH=1 still elaborates.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;
    logic              not_empty;

    // Wrap at DEPTH-1 explicitly; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign not_empty = (count_q != '0);

    // out_ready feeds in_ready combinationally so a full buffer can still
    // accept one payload per cycle while the head drains.
    assign up_if.ready = !freeze_i && !flush_i &&
                         ((count_q < CW'(DEPTH)) || dn_if.ready);
    assign dn_if.valid = not_empty && !freeze_i;
    assign dn_if.data  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

    assign push = up_if.valid && up_if.ready;
    assign pop  = dn_if.valid && dn_if.ready;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is never cleared; occupancy alone decides what is valid.
    // When full with push+pop, wr_ptr equals rd_ptr and the popped slot is
    // rewritten at the same edge it is released.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= up_if.data;
    end

`ifdef ELASTIC_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            full_q  <= '0;
        end else begin
            if (up_if.valid && !up_if.ready && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if ((count_q == CW'(DEPTH)) && (full_q != '1))
                full_q <= full_q + CNT_W'(1);
        end
    end

    assign stall_cycles_o = stall_q;
    assign full_cycles_o  = full_q;
`endif
endmodule

// File: tb/tb_elastic_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_elastic_stage_buf
//   DUT a: DEPTH=2 for directed scenarios with hand-derived expectations.
//   DUT b: DEPTH=3 driven by a toggling stream then random traffic, checked
//          against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_elastic_stage_buf;
    localparam int DW = 32;
    localparam logic [DW-1:0] DA = 32'hA, DB = 32'hB, DC = 32'hC;
    localparam logic [DW-1:0] DD = 32'hD, DE = 32'hE, DF = 32'hF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- DUT a (DEPTH=2) ----------------
    logic       a_flush = 1'b0, a_freeze = 1'b0;
    logic [1:0] a_cnt;
    elastic_stage_buf_if #(.DATA_W(DW)) a_up ();
    elastic_stage_buf_if #(.DATA_W(DW)) a_dn ();
`ifdef ELASTIC_PERF_CNT_EN
    logic [31:0] a_stall, a_full;
`endif

    elastic_stage_buf #(.DATA_W(DW), .DEPTH(2)) u_a (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (a_flush),
        .freeze_i       (a_freeze),
        .up_if          (a_up),
        .dn_if          (a_dn),
        .count_o        (a_cnt)
`ifdef ELASTIC_PERF_CNT_EN
        ,
        .stall_cycles_o (a_stall),
        .full_cycles_o  (a_full)
`endif
    );

    // ---------------- DUT b (DEPTH=3) ----------------
    logic       b_flush = 1'b0, b_freeze = 1'b0;
    logic [1:0] b_cnt;
    elastic_stage_buf_if #(.DATA_W(DW)) b_up ();
    elastic_stage_buf_if #(.DATA_W(DW)) b_dn ();
`ifdef ELASTIC_PERF_CNT_EN
    logic [31:0] b_stall, b_full;
`endif

    elastic_stage_buf #(.DATA_W(DW), .DEPTH(3)) u_b (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (b_flush),
        .freeze_i       (b_freeze),
        .up_if          (b_up),
        .dn_if          (b_dn),
        .count_o        (b_cnt)
`ifdef ELASTIC_PERF_CNT_EN
        ,
        .stall_cycles_o (b_stall),
        .full_cycles_o  (b_full)
`endif
    );

    // {out_valid, in_ready, count, out_data}
    wire [35:0] a_obs = {a_dn.valid, a_up.ready, a_cnt, a_dn.data};
    wire [35:0] b_obs = {b_dn.valid, b_up.ready, b_cnt, b_dn.data};

    initial begin
        a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
        b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;
    end

    // Inputs change 1 time unit after the edge; outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic ordy,
                           input logic frz, input logic fl);
        a_up.valid = v; a_up.data = d; a_dn.ready = ordy;
        a_freeze = frz; a_flush = fl;
        #1;
    endtask

    task automatic fill_ab();
        drive_a(1, DA, 0, 0, 0); tick();
        drive_a(1, DB, 0, 0, 0); tick();
    endtask

    task automatic test_reset();
        logic [35:0] exp;
        rst = 1'b1;
        drive_a(0, '0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0; #1;
        exp = {1'b0, 1'b1, 2'd0, 32'h0};
        tests++;
        if (a_obs !== exp) begin
            fails++; $display("FAIL reset obs=%h exp=%h", a_obs, exp);
        end
`ifdef ELASTIC_PERF_CNT_EN
        tests++;
        if ({a_stall, a_full} !== 64'h0) begin
            fails++; $display("FAIL reset_perf stall=%0d full=%0d exp=0", a_stall, a_full);
        end
`endif
    endtask

    task automatic test_pass_through();
        logic [35:0] exp [5];
        logic [35:0] obs [5];
        exp[0] = {1'b0, 1'b1, 2'd0, 32'h0};
        exp[1] = {1'b1, 1'b1, 2'd1, DA};
        exp[2] = {1'b1, 1'b1, 2'd1, DB};
        exp[3] = {1'b1, 1'b1, 2'd1, DC};
        exp[4] = {1'b0, 1'b1, 2'd0, 32'h0};
        drive_a(1, DA, 1, 0, 0); obs[0] = a_obs; tick();
        drive_a(1, DB, 1, 0, 0); obs[1] = a_obs; tick();
        drive_a(1, DC, 1, 0, 0); obs[2] = a_obs; tick();
        drive_a(0, '0, 1, 0, 0); obs[3] = a_obs; tick();
        obs[4] = a_obs;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (obs[i] !== exp[i]) begin
                fails++; $display("FAIL pass_through step%0d obs=%h exp=%h", i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] exp [8];
        logic [35:0] obs [8];
        exp[0] = {1'b0, 1'b1, 2'd0, 32'h0};
        exp[1] = {1'b1, 1'b1, 2'd1, DA};
        exp[2] = {1'b1, 1'b0, 2'd2, DA};
        exp[3] = {1'b1, 1'b0, 2'd2, DA};
        exp[4] = {1'b1, 1'b1, 2'd2, DA};
        exp[5] = {1'b1, 1'b1, 2'd2, DB};
        exp[6] = {1'b1, 1'b1, 2'd1, DC};
        exp[7] = {1'b0, 1'b1, 2'd0, 32'h0};
        drive_a(1, DA, 0, 0, 0); obs[0] = a_obs; tick();
        drive_a(1, DB, 0, 0, 0); obs[1] = a_obs; tick();
        drive_a(1, DC, 0, 0, 0); obs[2] = a_obs; tick();
        obs[3] = a_obs;
        drive_a(1, DC, 1, 0, 0); obs[4] = a_obs; tick();
        drive_a(0, '0, 1, 0, 0); obs[5] = a_obs; tick();
        obs[6] = a_obs; tick();
        obs[7] = a_obs;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (obs[i] !== exp[i]) begin
                fails++; $display("FAIL backpressure step%0d obs=%h exp=%h", i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_freeze();
        logic [35:0] exp;
        fill_ab();
        for (int i = 0; i < 5; i++) begin
            drive_a(1, DD, 1, 1, 0);
            exp = {1'b0, 1'b0, 2'd2, DA};
            tests++;
            if (a_obs !== exp) begin
                fails++; $display("FAIL freeze_hold cyc%0d obs=%h exp=%h", i, a_obs, exp);
            end
            tick();
        end
        drive_a(0, '0, 1, 0, 0);
        exp = {1'b1, 1'b1, 2'd2, DA};
        tests++;
        if (a_obs !== exp) begin
            fails++; $display("FAIL freeze_release obs=%h exp=%h", a_obs, exp);
        end
        tick();
        exp = {1'b1, 1'b1, 2'd1, DB};
        tests++;
        if (a_obs !== exp) begin
            fails++; $display("FAIL freeze_second obs=%h exp=%h", a_obs, exp);
        end
        tick();
    endtask

    task automatic test_flush();
        logic [35:0] exp [6];
        logic [35:0] obs [6];
        exp[0] = {1'b1, 1'b0, 2'd2, DA};
        exp[1] = {1'b0, 1'b1, 2'd0, 32'h0};
        exp[2] = {1'b1, 1'b1, 2'd1, DF};
        exp[3] = {1'b0, 1'b1, 2'd0, 32'h0};
        exp[4] = {1'b0, 1'b0, 2'd2, DA};
        exp[5] = {1'b0, 1'b1, 2'd0, 32'h0};
        fill_ab();
        drive_a(1, DE, 0, 0, 1); obs[0] = a_obs; tick();
        drive_a(1, DF, 0, 0, 0); obs[1] = a_obs; tick();
        obs[2] = a_obs;
        drive_a(0, '0, 1, 0, 0); tick();
        obs[3] = a_obs;
        // flush together with freeze still empties the buffer
        fill_ab();
        drive_a(1, DE, 1, 1, 1); obs[4] = a_obs; tick();
        drive_a(0, '0, 0, 0, 0); obs[5] = a_obs;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (obs[i] !== exp[i]) begin
                fails++; $display("FAIL flush step%0d obs=%h exp=%h", i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [35:0] exp;
        drive_a(1, DA, 0, 0, 0); tick();
        rst = 1'b1;
        drive_a(1, DB, 0, 0, 0); tick();
        rst = 1'b0;
        drive_a(0, '0, 0, 0, 0);
        exp = {1'b0, 1'b1, 2'd0, 32'h0};
        tests++;
        if (a_obs !== exp) begin
            fails++; $display("FAIL rst_mid obs=%h exp=%h", a_obs, exp);
        end
    endtask

`ifdef ELASTIC_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1; drive_a(0, '0, 0, 0, 0); tick(); rst = 1'b0;
        fill_ab();
        for (int i = 0; i < 4; i++) begin
            drive_a(1, DC, 0, 0, 0); tick();
        end
        tests++;
        if (a_stall !== 32'd4) begin
            fails++; $display("FAIL perf_stall obs=%0d exp=4", a_stall);
        end
        tests++;
        if (a_full < 32'd4) begin
            fails++; $display("FAIL perf_full obs=%0d exp>=4", a_full);
        end
        rst = 1'b1; drive_a(0, '0, 0, 0, 0); tick(); rst = 1'b0; #1;
        tests++;
        if ({a_stall, a_full} !== 64'h0) begin
            fails++; $display("FAIL perf_rst stall=%0d full=%0d exp=0", a_stall, a_full);
        end
    endtask
`endif

    // Reference model: a plain queue of held payloads, depth 3.
    task automatic test_random_model();
        logic [DW-1:0] q [$];
        logic [35:0]   exp;
        logic          v, ordy, frz, fl, e_rdy, e_vld;
        logic [DW-1:0] d;
        int            sent = 0, popped = 0, bad = 0;
        int            stall_m = 0, full_m = 0;
        rst = 1'b1; b_up.valid = 1'b0; b_dn.ready = 1'b0; tick(); rst = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc < 40) begin
                // ten payloads, out_ready toggling 1,0,1,0...
                v = (sent < 10); d = DW'(100 + sent);
                ordy = (cyc % 2 == 0); frz = 1'b0; fl = 1'b0;
            end else begin
                v    = ($urandom_range(3) != 0);
                d    = $urandom;
                ordy = $urandom_range(1) == 1;
                frz  = ($urandom_range(7) == 0);
                fl   = ($urandom_range(19) == 0);
            end
            b_up.valid = v; b_up.data = d; b_dn.ready = ordy;
            b_freeze = frz; b_flush = fl;
            #1;
            e_rdy = !frz && !fl && (q.size() < 3 || ordy);
            e_vld = (q.size() != 0) && !frz;
            exp = {e_vld, e_rdy, 2'(q.size()), (q.size() != 0) ? q[0] : 32'h0};
            if (b_obs !== exp && bad < 10) begin
                bad++;
                $display("FAIL random cyc%0d obs=%h exp=%h", cyc, b_obs, exp);
            end
            if (v && !e_rdy) stall_m++;
            if (q.size() == 3) full_m++;
            if (fl) q.delete();
            else begin
                if (e_vld && ordy) begin
                    void'(q.pop_front());
                    if (cyc < 40) popped++;
                end
                if (v && e_rdy) begin
                    q.push_back(d);
                    if (cyc < 40) sent++;
                end
            end
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL random_model mismatching_cycles=%0d exp=0", bad);
        end
        tests++;
        if (popped != 10) begin
            fails++; $display("FAIL toggle_stream popped=%0d exp=10", popped);
        end
`ifdef ELASTIC_PERF_CNT_EN
        tests++;
        if (b_stall !== 32'(stall_m) || b_full !== 32'(full_m)) begin
            fails++;
            $display("FAIL random_perf stall=%0d/%0d full=%0d/%0d (obs/exp)",
                     b_stall, stall_m, b_full, full_m);
        end
`endif
        b_up.valid = 1'b0; b_dn.ready = 1'b0; b_freeze = 1'b0; b_flush = 1'b0;
    endtask

    initial begin
        tick();
        test_reset();
        test_pass_through();
        test_backpressure();
        test_freeze();
        test_flush();
        test_rst_mid();
`ifdef ELASTIC_PERF_CNT_EN
        test_perf();
`endif
        test_random_model();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
